// File: rtl/riscv_mmio_pkg.sv
// rtl/riscv_mmio_pkg.sv - shared MMIO address map, UART status layout and FSM encoding
package riscv_mmio_pkg;

    localparam logic [31:0] LED_ADDR        = 32'h0000_1000;
    localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
    localparam logic [31:0] UART_STATUS_OFS = 32'd4;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_OCC_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Packs the UART status word; bits above the occupancy field read as zero.
    function automatic logic [31:0] uart_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [3:0] occ
    );
        logic [31:0] s;
        s                  = '0;
        s[ST_FULL]         = full;
        s[ST_EMPTY]        = empty;
        s[ST_BUSY]         = busy;
        s[ST_OVF]          = ovf;
        s[ST_OCC_LSB +: 4] = occ;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter int          CLK_HZ     = 20000000,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1004,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_20M,
    input  logic        rst,
    input  logic [31:0] daddr,
    input  logic [31:0] wdata,
    input  logic        dmem_w,
    input  logic        dmem_r,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int          DIV         = CLK_HZ / BAUD;
    localparam int          CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + UART_TXDATA_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + UART_STATUS_OFS;

    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [7:0]    sh;
    logic [7:0]    sh_next;
    logic          tx_next;
    logic          busy_next;

    logic          push_req;
    logic          push_eff;
    logic          status_rd;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic [AW:0]   count_next;
    logic [3:0]    occ;
    logic [31:0]   status;
    logic          ovf;

    logic          unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign push_req  = dmem_w && (daddr == TXDATA_ADDR);
    assign push_eff  = push_req && !fifo_full;
    assign status_rd = dmem_r && (daddr == STATUS_ADDR);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_20M),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer: next state, counters, pop request and the registered line value.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        sh_next    = sh;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sh_next    = fifo_dout;
                    cnt_next   = CNT_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_next   = CNT_RELOAD;
                    idx_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_next = CNT_RELOAD;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        sh_next    = fifo_dout;
                        cnt_next   = CNT_RELOAD;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // tx and tx_busy are registered from next-state values so they change on the decision edge.
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[idx_next];
            default: tx_next = 1'b1;
        endcase

        count_next = fifo_count + (AW+1)'(push_eff) - (AW+1)'(pop);
        busy_next  = (state_next != IDLE) || (count_next != '0);
    end

    // Status word; occupancy saturates at 15 so deeper FIFOs still fit the 4-bit field.
    always_comb begin
        occ    = (int'(fifo_count) > 15) ? 4'hF : 4'(fifo_count);
        status = uart_status(fifo_full, fifo_empty, tx_busy, ovf, occ);
    end

    // Transmit state registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk_20M) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            sh      <= sh_next;
            tx      <= tx_next;
            tx_busy <= busy_next;
        end
    end

    // Bus side: sticky overflow and one-cycle-late read data; an overflow wins over a clearing read.
    always_ff @(posedge clk_20M) begin
        if (rst) begin
            ovf   <= 1'b0;
            rdata <= '0;
        end else begin
            if (push_req && fifo_full) begin
                ovf <= 1'b1;
            end else if (status_rd) begin
                ovf <= 1'b0;
            end
            rdata <= status_rd ? status : '0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx with DIV=4
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1004;
    localparam logic [31:0] STAT = 32'h0000_1008;
    localparam logic [31:0] LED  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] daddr = '0;
    logic [31:0] wdata = '0;
    logic        dmem_w = 1'b0;
    logic        dmem_r = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          frames = 0;
    int          starts[$];
    logic [7:0]  tx_q[$];
    logic [31:0] rd_q[$];
    logic        mon_busy = 1'b0;
    logic        mon_abort = 1'b0;
    logic [7:0]  rx_byte;
    logic        stop_bit;
    logic        rd_pend = 1'b0;
    int          mon_start;

    mmio_uart_tx #(
        .CLK_HZ     (40),
        .BAUD       (10),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_20M (clk),
        .rst     (rst),
        .daddr   (daddr),
        .wdata   (wdata),
        .dmem_w  (dmem_w),
        .dmem_r  (dmem_r),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller must be at posedge+1; the store lands on the next edge.
    task automatic store(input logic [31:0] addr, input logic [7:0] data);
        daddr  = addr;
        wdata  = {24'h0, data};
        dmem_w = 1'b1;
        @(posedge clk);
        #1;
        dmem_w = 1'b0;
        daddr  = '0;
        wdata  = '0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] exp);
        daddr  = addr;
        dmem_r = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk);
        #1;
        dmem_r = 1'b0;
        daddr  = '0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((tx_busy || mon_busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_bound", 32'(k < 3000), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    // Line monitor: decodes 8N1 frames at bit centres and scores them against tx_q.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx == 1'b0) begin
                mon_busy  = 1'b1;
                mon_abort = 1'b0;
                mon_start = cyc;
                skip(6);
                rx_byte[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    skip(4);
                    rx_byte[i] = tx;
                end
                skip(4);
                stop_bit = tx;
                mon_busy = 1'b0;
                if (!mon_abort) begin
                    frames++;
                    starts.push_back(mon_start);
                    chk("stop_bit", 32'(stop_bit), 1);
                    if (tx_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got %h expected none", rx_byte);
                    end else begin
                        chk("rx_byte", 32'(rx_byte), 32'(tx_q.pop_front()));
                    end
                end
            end
        end
    end

    // Read monitor: rdata must match the queued value one cycle after a load, else be zero.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h expected none", rdata);
                end else begin
                    chk("rdata", rdata, rd_q.pop_front());
                end
            end else begin
                chk("rdata_idle", rdata, 0);
            end
            rd_pend = dmem_r;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got cycle %0d expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int fc0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(tx_busy), 0);
        chk("reset_rdata", rdata, 0);
        @(posedge clk);
        #1;
        load(STAT, 32'h0000_0002);

        // Single frame 0xA5 with start timing and busy duration
        tx_q.push_back(8'hA5);
        store(BASE, 8'hA5);
        @(negedge clk);
        chk("busy_on_push_edge", 32'(tx_busy), 1);
        chk("tx_high_on_push_edge", 32'(tx), 1);
        @(negedge clk);
        chk("start_bit_after_push", 32'(tx), 0);
        k = 0;
        while (tx_busy && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk("frame_busy_cycles", 32'(k), 40);
        wait_idle();

        // Three back-to-back frames
        fc0 = frames;
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h0F);
        tx_q.push_back(8'hFF);
        store(BASE, 8'h55);
        store(BASE, 8'h0F);
        store(BASE, 8'hFF);
        k = 0;
        @(negedge clk);
        while (tx_busy && k < 500) begin
            k++;
            @(negedge clk);
        end
        chk("burst_busy_cycles", 32'(k), 119);
        wait_idle();
        chk("burst_frames", 32'(frames - fc0), 3);
        if (starts.size() >= fc0 + 3) begin
            chk("gap_0_1", 32'(starts[fc0+1] - starts[fc0]), 40);
            chk("gap_1_2", 32'(starts[fc0+2] - starts[fc0+1]), 40);
        end else begin
            total++;
            bad++;
            $display("FAIL burst_starts: got %0d expected %0d", starts.size(), fc0 + 3);
        end

        // Overflow: ten stores, ninth fills the FIFO, tenth is dropped
        fc0 = frames;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_q.push_back(8'h11 + 8'(i));
            store(BASE, 8'h11 + 8'(i));
        end
        load(STAT, 32'h0000_008D);
        load(STAT, 32'h0000_0085);
        wait_idle();
        chk("overflow_frames", 32'(frames - fc0), 9);

        // Reset in the middle of data bit 3
        fc0 = frames;
        store(BASE, 8'h3C);
        repeat (17) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tx_after_reset", 32'(tx), 1);
        chk("busy_after_reset", 32'(tx_busy), 0);
        @(posedge clk);
        #1;
        load(STAT, 32'h0000_0002);
        repeat (60) @(posedge clk);
        #1;
        chk("no_frame_after_reset", 32'(frames - fc0), 0);

        // Non-TXDATA accesses leave the FIFO untouched
        fc0 = frames;
        store(STAT, 8'h77);
        store(LED, 8'h66);
        @(negedge clk);
        chk("busy_after_other_stores", 32'(tx_busy), 0);
        @(posedge clk);
        #1;
        load(BASE, 32'h0000_0000);
        load(LED, 32'h0000_0000);
        load(STAT, 32'h0000_0002);
        repeat (60) @(posedge clk);
        #1;
        chk("no_frame_other_stores", 32'(frames - fc0), 0);
        chk("tx_q_drained", 32'(tx_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
